// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared constants, entry flag layout and tag wrap helper for the reorder buffer
// Purpose: default sizing of the reorder buffer, per-entry state flags,
// and the increment-with-wrap used for head/tail (depth need not be 2^n).
// Ports: none (package).
package rob_pkg;

    localparam int DEFAULT_NUM_GPR        = 32;
    localparam int DEFAULT_NUM_ROB_ENTRY  = 8;
    localparam int DEFAULT_NUM_WB_PORT    = 2;
    localparam int DEFAULT_TYPE_W         = 6;
    localparam int DEFAULT_VALUE_W        = 64;
    localparam int NUM_SRC                = 2;

    // Entry layout: these flags plus type, dst and value arrays held in the top.
    typedef struct packed {
        logic valid;
        logic done;
        logic exception;
    } entry_flags_t;

    // Wraps explicitly at num_entry-1 so non-power-of-two depths work.
    function automatic int tag_inc(input int tag, input int num_entry);
        return (tag == num_entry - 1) ? 0 : tag + 1;
    endfunction

endpackage

// File: rtl/register_status_table.sv
// rtl/register_status_table.sv - busy bit and producing tag per architectural register
// Purpose: records which ROB entry will produce each architectural register.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      clear every busy bit
//   set_en/set_reg/set_tag     mark set_reg busy with set_tag (x0 ignored)
//   clear_en/clear_reg/clear_tag  clear busy only if the recorded tag still matches
//   lookup_reg                 two flattened source registers (LSB first)
//   lookup_busy/lookup_tag     busy bit and producing tag per source
module register_status_table
    import rob_pkg::*;
#(
    parameter int NUM_REG = DEFAULT_NUM_GPR,
    parameter int TAG_W   = 3,
    parameter int REG_W   = $clog2(NUM_REG)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     set_en,
    input  logic [REG_W-1:0]         set_reg,
    input  logic [TAG_W-1:0]         set_tag,
    input  logic                     clear_en,
    input  logic [REG_W-1:0]         clear_reg,
    input  logic [TAG_W-1:0]         clear_tag,
    input  logic [NUM_SRC*REG_W-1:0] lookup_reg,
    output logic [NUM_SRC-1:0]       lookup_busy,
    output logic [NUM_SRC*TAG_W-1:0] lookup_tag
);

    logic [NUM_REG-1:0] busy;
    logic [TAG_W-1:0]   tag_table [NUM_REG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            for (int i = 0; i < NUM_REG; i++) tag_table[i] <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            // Only the youngest producer may release the register.
            if (clear_en && tag_table[clear_reg] == clear_tag)
                busy[clear_reg] <= 1'b0;
            // Placed after the clear so a same-cycle dispatch to the same dst wins.
            if (set_en && set_reg != '0) begin
                busy[set_reg]      <= 1'b1;
                tag_table[set_reg] <= set_tag;
            end
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_lookup
        logic [REG_W-1:0] r;
        assign r = lookup_reg[s*REG_W +: REG_W];
        assign lookup_busy[s]                = busy[r] && (r != '0);
        assign lookup_tag[s*TAG_W +: TAG_W]  = tag_table[r];
    end

endmodule

// File: rtl/reorder_buffer_multiport.sv
// rtl/reorder_buffer_multiport.sv - in-order retire reorder buffer with multiple writeback ports
// Purpose: allocates one entry per cycle, accepts results on several writeback
// ports, retires from the head, forwards completed values to source lookups.
// Ports:
//   clk_in, reset_in           clock, asynchronous active-low reset
//   dispatch_*                 allocation handshake, dst/type, source lookup results
//   wb_*                       per-port result writeback (flattened LSB-first)
//   commit_*                   head retirement handshake and payload
//   flush_in                   discard all entries and register status
//   empty_out/full_out/count_out  occupancy
module reorder_buffer_multiport
    import rob_pkg::*;
#(
    parameter int NUM_GENERAL_PURPOSE_REGISTER       = DEFAULT_NUM_GPR,
    parameter int NUM_ROB_ENTRY                      = DEFAULT_NUM_ROB_ENTRY,
    parameter int NUM_WRITEBACK_PORT                 = DEFAULT_NUM_WB_PORT,
    parameter int ROB_INSTRUCTION_TYPE_WIDTH_IN_BITS = DEFAULT_TYPE_W,
    parameter int ROB_VALUE_WIDTH_IN_BITS            = DEFAULT_VALUE_W,
    parameter int ROB_TAG_WIDTH_IN_BITS              = $clog2(NUM_ROB_ENTRY),
    parameter int REG_W                              = $clog2(NUM_GENERAL_PURPOSE_REGISTER),
    parameter int COUNT_W                            = $clog2(NUM_ROB_ENTRY + 1)
) (
    input  logic                                          clk_in,
    input  logic                                          reset_in,
    input  logic                                          dispatch_valid_in,
    output logic                                          dispatch_ack_out,
    input  logic [ROB_INSTRUCTION_TYPE_WIDTH_IN_BITS-1:0] dispatch_instruction_type_in,
    input  logic [REG_W-1:0]                              dispatch_dst_in,
    output logic [ROB_TAG_WIDTH_IN_BITS-1:0]              dispatch_rob_tag_out,
    input  logic [NUM_SRC*REG_W-1:0]                      dispatch_src_in,
    output logic [NUM_SRC-1:0]                            dispatch_src_busy_out,
    output logic [NUM_SRC*ROB_TAG_WIDTH_IN_BITS-1:0]      dispatch_src_tag_out,
    output logic [NUM_SRC-1:0]                            dispatch_src_value_ready_out,
    output logic [NUM_SRC*ROB_VALUE_WIDTH_IN_BITS-1:0]    dispatch_src_value_out,
    input  logic [NUM_WRITEBACK_PORT-1:0]                 wb_valid_in,
    input  logic [NUM_WRITEBACK_PORT*ROB_TAG_WIDTH_IN_BITS-1:0]   wb_tag_in,
    input  logic [NUM_WRITEBACK_PORT*ROB_VALUE_WIDTH_IN_BITS-1:0] wb_value_in,
    input  logic [NUM_WRITEBACK_PORT-1:0]                 wb_exception_in,
    output logic                                          commit_valid_out,
    input  logic                                          commit_ready_in,
    output logic [REG_W-1:0]                              commit_dst_out,
    output logic [ROB_VALUE_WIDTH_IN_BITS-1:0]            commit_value_out,
    output logic [ROB_INSTRUCTION_TYPE_WIDTH_IN_BITS-1:0] commit_instruction_type_out,
    output logic                                          commit_exception_out,
    input  logic                                          flush_in,
    output logic                                          empty_out,
    output logic                                          full_out,
    output logic [COUNT_W-1:0]                            count_out
);

    localparam int TAG_W  = ROB_TAG_WIDTH_IN_BITS;
    localparam int VAL_W  = ROB_VALUE_WIDTH_IN_BITS;
    localparam int TYPE_W = ROB_INSTRUCTION_TYPE_WIDTH_IN_BITS;

    logic [TAG_W-1:0]   head, tail;
    logic [COUNT_W-1:0] count;

    entry_flags_t       flags     [NUM_ROB_ENTRY];
    logic [TYPE_W-1:0]  ent_type  [NUM_ROB_ENTRY];
    logic [REG_W-1:0]   ent_dst   [NUM_ROB_ENTRY];
    logic [VAL_W-1:0]   ent_value [NUM_ROB_ENTRY];

    logic full, dispatch_fire, commit_fire, do_flush;
    logic [TAG_W-1:0] wb_tag      [NUM_WRITEBACK_PORT];
    logic             wb_in_range [NUM_WRITEBACK_PORT];

    assign full          = (count == COUNT_W'(NUM_ROB_ENTRY));
    assign dispatch_fire = dispatch_valid_in && !full;
    assign commit_valid_out = flags[head].valid && flags[head].done;
    assign commit_fire   = commit_valid_out && commit_ready_in;
    assign do_flush      = flush_in || (commit_fire && flags[head].exception);

    for (genvar p = 0; p < NUM_WRITEBACK_PORT; p++) begin : g_wb
        assign wb_tag[p]      = wb_tag_in[p*TAG_W +: TAG_W];
        // Guards against tags past the last entry when depth is not 2^n.
        assign wb_in_range[p] = (32'(wb_tag[p]) < NUM_ROB_ENTRY);
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < NUM_ROB_ENTRY; i++) begin
                flags[i]     <= '0;
                ent_type[i]  <= '0;
                ent_dst[i]   <= '0;
                ent_value[i] <= '0;
            end
        end else if (do_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < NUM_ROB_ENTRY; i++) flags[i] <= '0;
        end else begin
            if (dispatch_fire) begin
                flags[tail]    <= '{valid: 1'b1, done: 1'b0, exception: 1'b0};
                ent_type[tail] <= dispatch_instruction_type_in;
                ent_dst[tail]  <= dispatch_dst_in;
                tail           <= TAG_W'(tag_inc(int'(tail), NUM_ROB_ENTRY));
            end
            // Ascending port order: the highest-index port wins on a tag collision.
            for (int p = 0; p < NUM_WRITEBACK_PORT; p++) begin
                if (wb_valid_in[p] && wb_in_range[p] && flags[wb_tag[p]].valid) begin
                    flags[wb_tag[p]].done      <= 1'b1;
                    flags[wb_tag[p]].exception <= wb_exception_in[p];
                    ent_value[wb_tag[p]]       <= wb_value_in[p*VAL_W +: VAL_W];
                end
            end
            if (commit_fire) begin
                flags[head].valid <= 1'b0;
                head              <= TAG_W'(tag_inc(int'(head), NUM_ROB_ENTRY));
            end
            count <= count + COUNT_W'(dispatch_fire) - COUNT_W'(commit_fire);
        end
    end

    register_status_table #(
        .NUM_REG (NUM_GENERAL_PURPOSE_REGISTER),
        .TAG_W   (TAG_W),
        .REG_W   (REG_W)
    ) u_status (
        .clk         (clk_in),
        .rst_n       (reset_in),
        .flush       (do_flush),
        .set_en      (dispatch_fire),
        .set_reg     (dispatch_dst_in),
        .set_tag     (tail),
        .clear_en    (commit_fire),
        .clear_reg   (ent_dst[head]),
        .clear_tag   (head),
        .lookup_reg  (dispatch_src_in),
        .lookup_busy (dispatch_src_busy_out),
        .lookup_tag  (dispatch_src_tag_out)
    );

    // Forward completed results; values written this cycle appear next cycle.
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [TAG_W-1:0] t;
        assign t = dispatch_src_tag_out[s*TAG_W +: TAG_W];
        assign dispatch_src_value_ready_out[s] = dispatch_src_busy_out[s] && flags[t].done;
        assign dispatch_src_value_out[s*VAL_W +: VAL_W] =
            dispatch_src_busy_out[s] ? ent_value[t] : '0;
    end

    assign dispatch_ack_out            = !full;
    assign dispatch_rob_tag_out        = tail;
    assign commit_dst_out              = ent_dst[head];
    assign commit_value_out            = ent_value[head];
    assign commit_instruction_type_out = ent_type[head];
    assign commit_exception_out        = flags[head].exception;
    assign empty_out                   = (count == '0);
    assign full_out                    = full;
    assign count_out                   = count;

endmodule

// File: tb/tb_reorder_buffer_multiport.sv
// tb/tb_reorder_buffer_multiport.sv - directed self-checking bench for reorder_buffer_multiport
module tb_reorder_buffer_multiport;

    logic         clk = 1'b0;
    logic         reset_in = 1'b0;
    logic         dispatch_valid = 1'b0;
    logic [5:0]   dispatch_type = '0;
    logic [4:0]   dispatch_dst = '0;
    logic [9:0]   dispatch_src = '0;
    logic [1:0]   wb_valid = '0;
    logic [5:0]   wb_tag = '0;
    logic [127:0] wb_value = '0;
    logic [1:0]   wb_exc = '0;
    logic         commit_ready = 1'b0;
    logic         flush = 1'b0;

    // 8-entry instance outputs
    logic         ack, commit_valid, commit_exc, empty, full;
    logic [2:0]   rob_tag;
    logic [1:0]   src_busy, src_ready;
    logic [5:0]   src_tag;
    logic [127:0] src_value;
    logic [4:0]   commit_dst;
    logic [63:0]  commit_value;
    logic [5:0]   commit_type;
    logic [3:0]   count;

    // 6-entry instance outputs (same stimulus)
    logic         ack_s, commit_valid_s, commit_exc_s, empty_s, full_s;
    logic [2:0]   rob_tag_s;
    logic [1:0]   src_busy_s, src_ready_s;
    logic [5:0]   src_tag_s;
    logic [127:0] src_value_s;
    logic [4:0]   commit_dst_s;
    logic [63:0]  commit_value_s;
    logic [5:0]   commit_type_s;
    logic [2:0]   count_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reorder_buffer_multiport dut (
        .clk_in(clk), .reset_in(reset_in),
        .dispatch_valid_in(dispatch_valid), .dispatch_ack_out(ack),
        .dispatch_instruction_type_in(dispatch_type), .dispatch_dst_in(dispatch_dst),
        .dispatch_rob_tag_out(rob_tag), .dispatch_src_in(dispatch_src),
        .dispatch_src_busy_out(src_busy), .dispatch_src_tag_out(src_tag),
        .dispatch_src_value_ready_out(src_ready), .dispatch_src_value_out(src_value),
        .wb_valid_in(wb_valid), .wb_tag_in(wb_tag), .wb_value_in(wb_value),
        .wb_exception_in(wb_exc),
        .commit_valid_out(commit_valid), .commit_ready_in(commit_ready),
        .commit_dst_out(commit_dst), .commit_value_out(commit_value),
        .commit_instruction_type_out(commit_type), .commit_exception_out(commit_exc),
        .flush_in(flush), .empty_out(empty), .full_out(full), .count_out(count)
    );

    reorder_buffer_multiport #(.NUM_ROB_ENTRY(6)) dut_s (
        .clk_in(clk), .reset_in(reset_in),
        .dispatch_valid_in(dispatch_valid), .dispatch_ack_out(ack_s),
        .dispatch_instruction_type_in(dispatch_type), .dispatch_dst_in(dispatch_dst),
        .dispatch_rob_tag_out(rob_tag_s), .dispatch_src_in(dispatch_src),
        .dispatch_src_busy_out(src_busy_s), .dispatch_src_tag_out(src_tag_s),
        .dispatch_src_value_ready_out(src_ready_s), .dispatch_src_value_out(src_value_s),
        .wb_valid_in(wb_valid), .wb_tag_in(wb_tag), .wb_value_in(wb_value),
        .wb_exception_in(wb_exc),
        .commit_valid_out(commit_valid_s), .commit_ready_in(commit_ready),
        .commit_dst_out(commit_dst_s), .commit_value_out(commit_value_s),
        .commit_instruction_type_out(commit_type_s), .commit_exception_out(commit_exc_s),
        .flush_in(flush), .empty_out(empty_s), .full_out(full_s), .count_out(count_s)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        dispatch_valid = 1'b0;
        wb_valid = '0;
        wb_exc = '0;
        flush = 1'b0;
    endtask

    task automatic disp(input logic [4:0] dst);
        dispatch_valid = 1'b1;
        dispatch_dst = dst;
        dispatch_type = 6'h20 | {1'b0, dst};
    endtask

    task automatic wb(input int p, input logic [2:0] t, input logic [63:0] v, input logic e);
        wb_valid[p] = 1'b1;
        wb_tag[p*3 +: 3] = t;
        wb_value[p*64 +: 64] = v;
        wb_exc[p] = e;
    endtask

    task automatic do_reset;
        idle();
        commit_ready = 1'b0;
        reset_in = 1'b0;
        step();
        step();
        reset_in = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ---- reset state ----
        do_reset();
        check("rst_ack", ack, 1);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_commit_value", commit_value, 0);

        // ---- fill 8 entries, dst 1..8 ----
        for (int i = 0; i < 8; i++) begin
            disp(5'(i + 1));
            check("alloc_tag", rob_tag, 64'(i));
            step();
        end
        idle();
        check("fill_full", full, 1);
        check("fill_ack", ack, 0);
        check("fill_count", count, 8);
        dispatch_src = {5'd8, 5'd1};
        #1;
        check("fill_busy", src_busy, 2'b11);
        check("fill_src_tag", src_tag, 6'h38);
        check("fill_ready", src_ready, 2'b00);
        disp(5'd9);
        step();
        idle();
        check("full_no_alloc_count", count, 8);
        check("full_no_alloc_tag", rob_tag, 0);
        dispatch_src = {5'd9, 5'd9};
        #1;
        check("full_no_alloc_busy", src_busy, 2'b00);

        // ---- out-of-order writeback ----
        wb(0, 3'd3, 64'hAA, 1'b0);
        step();
        idle();
        check("wb3_no_commit", commit_valid, 0);
        wb(1, 3'd0, 64'hBB, 1'b0);
        step();
        idle();
        check("wb0_commit_valid", commit_valid, 1);
        check("wb0_commit_dst", commit_dst, 1);
        check("wb0_commit_value", commit_value, 64'hBB);
        check("wb0_commit_type", commit_type, 6'h21);
        commit_ready = 1'b1;
        step();
        check("c0_count", count, 7);
        check("c0_ack", ack, 1);
        check("c0_hold_tag3", commit_valid, 0);
        dispatch_src = {5'd4, 5'd1};
        #1;
        check("c0_busy", src_busy, 2'b10);
        check("c0_ready", src_ready, 2'b10);
        check("c0_fwd_value", src_value[127:64], 64'hAA);
        wb(0, 3'd1, 64'h11, 1'b0);
        wb(1, 3'd2, 64'h22, 1'b0);
        step();
        idle();
        check("c1_dst", commit_dst, 2);
        check("c1_value", commit_value, 64'h11);
        step();
        check("c2_dst", commit_dst, 3);
        check("c2_value", commit_value, 64'h22);
        step();
        check("c3_dst", commit_dst, 4);
        check("c3_value", commit_value, 64'hAA);
        step();
        check("c4_not_done", commit_valid, 0);
        check("c4_count", count, 4);
        commit_ready = 1'b0;

        // ---- repeated dst, youngest producer kept ----
        do_reset();
        dispatch_src = {5'd5, 5'd5};
        disp(5'd5);
        #1;
        check("dup_first_src_busy", src_busy, 2'b00);
        step();
        disp(5'd5);
        #1;
        check("dup_older_busy", src_busy, 2'b11);
        check("dup_older_tag", src_tag, 6'h00);
        step();
        idle();
        wb(0, 3'd0, 64'h50, 1'b0);
        step();
        idle();
        commit_ready = 1'b1;
        step();
        commit_ready = 1'b0;
        check("dup_still_busy", src_busy, 2'b11);
        check("dup_tag1", src_tag, 6'h09);
        check("dup_not_ready", src_ready, 2'b00);
        wb(1, 3'd1, 64'h55, 1'b0);
        step();
        idle();
        check("dup_fwd_ready", src_ready, 2'b11);
        check("dup_fwd_value", src_value[63:0], 64'h55);
        commit_ready = 1'b1;
        step();
        commit_ready = 1'b0;
        check("dup_released", src_busy, 2'b00);
        check("dup_empty", empty, 1);

        // ---- dispatch overrides same-cycle commit clear ----
        disp(5'd6);
        check("ovr_tag", rob_tag, 2);
        step();
        idle();
        wb(0, 3'd2, 64'h66, 1'b0);
        step();
        idle();
        disp(5'd6);
        commit_ready = 1'b1;
        step();
        idle();
        commit_ready = 1'b0;
        dispatch_src = {5'd6, 5'd6};
        #1;
        check("ovr_count", count, 1);
        check("ovr_busy", src_busy, 2'b11);
        check("ovr_src_tag", src_tag, 6'h1B);

        // ---- 6-entry instance: full + commit + dispatch, tail wrap ----
        do_reset();
        for (int i = 0; i < 6; i++) begin
            disp(5'(i + 1));
            check("s_alloc_tag", rob_tag_s, 64'(i));
            step();
        end
        idle();
        check("s_full", full_s, 1);
        check("s_ack", ack_s, 0);
        check("s_tail_wrap", rob_tag_s, 0);
        wb(0, 3'd0, 64'h77, 1'b0);
        step();
        idle();
        disp(5'd9);
        commit_ready = 1'b1;
        check("s_full_commit_ack", ack_s, 0);
        step();
        commit_ready = 1'b0;
        check("s_no_passthrough_count", count_s, 5);
        check("s_ack_rise", ack_s, 1);
        check("s_next_tag", rob_tag_s, 0);
        step();
        idle();
        check("s_wrap_alloc_count", count_s, 6);
        check("s_wrap_alloc_tail", rob_tag_s, 1);

        // ---- exception commit flushes ----
        do_reset();
        disp(5'd7);
        step();
        disp(5'd8);
        step();
        idle();
        wb(0, 3'd0, 64'hEE, 1'b1);
        step();
        idle();
        check("exc_commit_valid", commit_valid, 1);
        check("exc_flag", commit_exc, 1);
        check("exc_dst", commit_dst, 7);
        commit_ready = 1'b1;
        step();
        commit_ready = 1'b0;
        dispatch_src = {5'd8, 5'd7};
        #1;
        check("exc_empty", empty, 1);
        check("exc_count", count, 0);
        check("exc_commit_cleared", commit_valid, 0);
        check("exc_not_busy", src_busy, 2'b00);

        // ---- explicit flush with concurrent dispatch and writeback ----
        do_reset();
        for (int i = 0; i < 4; i++) begin
            disp(5'(i + 1));
            step();
        end
        idle();
        flush = 1'b1;
        disp(5'd10);
        wb(0, 3'd0, 64'h12, 1'b0);
        check("flush_ack_pre", ack, 1);
        step();
        idle();
        dispatch_src = {5'd10, 5'd1};
        #1;
        check("flush_empty", empty, 1);
        check("flush_count", count, 0);
        check("flush_tail", rob_tag, 0);
        check("flush_not_busy", src_busy, 2'b00);
        step();
        check("flush_no_commit", commit_valid, 0);

        // ---- asynchronous reset mid-run ----
        disp(5'd1);
        step();
        disp(5'd2);
        step();
        idle();
        wb(0, 3'd0, 64'h34, 1'b0);
        step();
        idle();
        check("mid_pre_commit_valid", commit_valid, 1);
        #2;
        reset_in = 1'b0;
        #1;
        check("mid_async_empty", empty, 1);
        check("mid_async_count", count, 0);
        check("mid_async_no_commit", commit_valid, 0);
        step();
        reset_in = 1'b1;
        step();
        check("mid_after_commit", commit_valid, 0);
        check("mid_after_ack", ack, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
